two_bit_up: RTL and testbench
=============================

// Module: two_bit_up
// PURPOSE
//   Dual 2-bit up counter driven by one count-request input t, single clock domain.
//   Output a is a level-sensitive counter: it advances on every clock edge where t is high.
//     It is built as a synchronous T flip-flop chain.
//   Output b is an event counter: it advances once per 0->1 transition of t, on the
//     clock edge where that transition is sampled.
//   Used as a small timing-demo / glue block, so trigger-to-output timing can be compared
//     between the two counting styles.
// PARAMETERS
//   WIDTH      2     counter width in bits (a and b); all arithmetic is modulo 2**WIDTH
// PORTS
//   clk        in    1      rising-edge clock; the only clock
//   reset      in    1      synchronous reset, active-high; clears all state
//   t          in    1      count request, sampled on rising clk; no synchronizer inside
//   a          out   WIDTH  level counter value, registered
//   b          out   WIDTH  edge counter value, registered
// BEHAVIOUR
//   Clocking and reset
//     - All state updates on rising clk only; no combinational path from t to a or b.
//     - reset=1 at a rising edge: a<=0, b<=0, t_q<=0 (internal copy of t).
//       Reset has priority over t.
//     - Power-up contents are not guaranteed (X in simulation) until the first reset edge.
//   Counter a (T flip-flop chain)
//     - Per edge with reset=0: bit0 toggles if t=1.
//       Bit i (i>0) toggles if t=1 and bits 0..i-1 are all 1.
//     - Net effect: a <= a + t, modulo 2**WIDTH, so 3->0 when WIDTH=2.
//     - t held high for N edges advances a by N.
//   Counter b (edge counter)
//     - t_q <= t on every non-reset edge.
//     - rise = t & ~t_q.
//     - rise=1: b <= b + 1, modulo 2**WIDTH, wraps 3->0.
//       Otherwise b holds.
//     - t held high for N edges advances b by exactly 1.
//   Timing
//     - Latency: a and b show the new value right after the clock edge that samples t.
//       Zero extra cycles.
//     - On the first edge that samples t=1 after t was low, a and b both increment together.
//     - A t pulse that contains no rising clk edge is not counted by either counter.
//   Boundary cases
//     - Reset asserted mid-count: both counters read 0 after that edge, whatever t is.
//     - t=1 on the first edge after reset is released: t_q was cleared, so this counts as a
//       rise; a=1, b=1.
//     - Reset and t=1 on the same edge: reset wins; a=0, b=0, t_q=0.
//     - Both counters wrap silently. There is no carry or overflow output.
//   Derived debug signal
//     - A 2-bit debug vector {a[0], b[0]} must be formable externally.
//     - No internal logic depends on it.
// TESTING
//   1. reset=1 for 2 edges, t=0 -> a=0, b=0; hold t=0 for 5 edges -> a=0, b=0 unchanged.
//   2. After reset, t=1 for 1 edge then t=0 for 3 edges, repeated 4 times:
//      a and b both step 1,2,3,0, one step per pulse edge.
//   3. After reset, t held 1 for 6 edges -> a sequence 1,2,3,0,1,2; b=1 and stays 1.
//      Then t=0 for 1 edge and t=1 for 1 edge -> a=3, b=2.
//   4. With a=2, b=2: assert reset together with t=1 -> both 0 on that edge.
//      Release reset with t still 1 -> a=1, b=1 next edge.
//   5. t pulse of 20 ns with clk period 40 ns, pulse placed entirely between rising edges
//      -> a and b unchanged.
//      Same pulse straddling a rising edge -> a+1 and b+1 on that edge.
//   6. WIDTH=3 build, t held 1 for 9 edges after reset -> a=1 (wrapped 7->0->1); b=1.

Source files
------------

// File: rtl/two_bit_up_if.sv
// Purpose : bundles the count request and both counter values of two_bit_up.
// Ports   : t (count request, driven by master), a (level count), b (edge count).
// Modports: master drives t and observes a/b; slave (the counter) does the reverse.
interface two_bit_up_if #(
  parameter int WIDTH = 2
);
  logic             t;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  modport master (
    output t,
    input  a,
    input  b
  );

  modport slave (
    input  t,
    output a,
    output b
  );
endinterface

// File: rtl/two_bit_up.sv
// Purpose : dual up counter; a counts clock edges with t high, b counts 0->1 edges of t.
// Latency : a and b update on the same rising clk that samples t; no comb path t->a/b.
// Backpr. : none; t is sampled every edge and both counters wrap silently modulo 2**WIDTH.
// Ports   : clk (rising-edge clock), reset (sync, active-high, beats t),
//           bus.t (count request), bus.a (level counter), bus.b (edge counter).
//           {a[0], b[0]} can be formed outside as a debug vector; nothing here uses it.
module two_bit_up #(
  parameter int WIDTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  two_bit_up_if.slave   bus
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             t_q;
  logic [WIDTH-1:0] toggle;
  logic             rise;

  // Synchronous T flip-flop chain: bit i toggles when t is high and every
  // lower bit is already 1, which gives a <= a + t modulo 2**WIDTH.
  assign toggle[0] = bus.t;
  for (genvar i = 1; i < WIDTH; i++) begin : g_tchain
    assign toggle[i] = toggle[i-1] & a_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
    end else begin
      a_q <= a_q ^ toggle;
    end
  end

  // t_q is cleared by reset, so t already high on the first edge after
  // reset release counts as a rise.
  assign rise = bus.t & ~t_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q <= 1'b0;
      b_q <= '0;
    end else begin
      t_q <= bus.t;
      if (rise) begin
        b_q <= b_q + WIDTH'(1);
      end
    end
  end

  assign bus.a = a_q;
  assign bus.b = b_q;

endmodule

// File: tb/tb_two_bit_up.sv
// Purpose : self-checking bench for two_bit_up at WIDTH=2 and WIDTH=3, directed + random.
// Latency : expected values are checked 1 ns after each rising edge.
// Backpr. : none; t and reset are driven on the falling edge except in pulse tests.
module tb_two_bit_up;

  logic clk;
  logic reset;
  logic t;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain event counts, reduced modulo 2**WIDTH when compared.
  int m_level;   // number of edges that sampled t=1 since reset
  int m_rises;   // number of edges where t=1 and previous sampled t was 0
  bit m_prev_t;
  bit m_valid = 1'b0;

  two_bit_up_if #(.WIDTH(2)) bus2 ();
  two_bit_up_if #(.WIDTH(3)) bus3 ();

  assign bus2.t = t;
  assign bus3.t = t;

  two_bit_up #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  two_bit_up #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  // 40 ns period, rising edges at 20, 60, 100, ...
  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_level  = 0;
      m_rises  = 0;
      m_prev_t = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      if (t === 1'b1) begin
        m_level = m_level + 1;
        if (!m_prev_t) m_rises = m_rises + 1;
      end
      m_prev_t = (t === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [2:0] obs, input int exp);
    logic [2:0] e;
    e = exp[2:0];
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  task automatic chk_model();
    if (m_valid) begin
      chk("model_a2", {1'b0, bus2.a}, m_level % 4);
      chk("model_b2", {1'b0, bus2.b}, m_rises % 4);
      chk("model_a3", bus3.a, m_level % 8);
      chk("model_b3", bus3.b, m_rises % 8);
    end
  endtask

  task automatic chk2(input string tag, input int ea, input int eb);
    chk({tag, "_a"}, {1'b0, bus2.a}, ea);
    chk({tag, "_b"}, {1'b0, bus2.b}, eb);
  endtask

  // Drive on the falling edge, then look 1 ns after the next rising edge.
  task automatic tick(input logic r, input logic tv);
    @(negedge clk);
    reset = r;
    t     = tv;
    @(posedge clk);
    #1;
    chk_model();
  endtask

  initial begin
    reset = 1'b1;
    t     = 1'b0;

    // 1: reset, then idle
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk2("reset", 0, 0);
    chk("reset_a3", bus3.a, 0);
    chk("reset_b3", bus3.b, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      chk2("idle", 0, 0);
    end

    // 2: single-edge pulses step both counters 1,2,3,0
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 1'b1);
      chk2("pulse", k % 4, k % 4);
      for (int j = 0; j < 3; j++) begin
        tick(1'b0, 1'b0);
        chk2("pulse_hold", k % 4, k % 4);
      end
    end

    // 3: t held high advances a each edge, b only once
    tick(1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 1'b1);
      chk2("held", i % 4, 1);
    end
    tick(1'b0, 1'b0);
    chk2("held_low", 2, 1);
    tick(1'b0, 1'b1);
    chk2("held_rise", 3, 2);

    // 4: reset together with t=1, then release with t still high
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk2("pre_reset", 2, 2);
    tick(1'b1, 1'b1);
    chk2("reset_with_t", 0, 0);
    tick(1'b0, 1'b1);
    chk2("release_t_high", 1, 1);

    // 5: 20 ns pulse between edges is ignored; straddling an edge counts
    tick(1'b0, 1'b0);
    chk2("pulse5_base", 1, 1);
    #9 t = 1'b1;            // edge+10
    #20 t = 1'b0;           // edge+30, next edge at +40
    @(posedge clk);
    #1;
    chk_model();
    chk2("pulse_between", 1, 1);
    #29 t = 1'b1;           // edge+30
    @(posedge clk);
    #10 t = 1'b0;           // edge+10, pulse spans the rising edge
    chk_model();
    chk2("pulse_straddle", 2, 2);

    // 6: WIDTH=3 wraps 7->0->1 after 9 held edges
    tick(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);
    chk("w3_a", bus3.a, 1);
    chk("w3_b", bus3.b, 1);
    chk2("w3_w2", 1, 1);

    // Random traffic with occasional reset, checked against the model
    tick(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
